note_key_encoder: RTL and testbench
===================================

# note_key_encoder

Front-end of the free-play path. Takes the raw note keys and the octave button from the board, synchronises and debounces each one, and priority-encodes the held key into the 4-bit note code and the `higher_8` flag consumed by the free-mode player. It also emits a one-cycle pulse whenever the encoded note changes, so downstream display and buzzer logic can restart cleanly.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive stable cycles required to accept a level change (20 ms at 100 MHz). Legal range is ≥2. The counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `key_in`  in  7  raw note keys, active-high. Bit i selects scale degree i+1 (do..si).
- `octave_btn`  in  1  raw octave push-button, active-high.
- `note_out`  out  4  encoded note (registered):
  - 0 = rest;
  - 1..7 = low octave;
  - 9..15 = high octave;
  - 8 is never produced.
- `higher_8`  out  1  octave flag (registered). When 1, `note_out` = degree + 8.
- `note_change`  out  1  one-cycle pulse, high in the cycle after `note_out` takes a new value.

## Operation
- **Per-input path** (8 identical channels: `key_in[6:0]` and `octave_btn`):
  - A 2-flop synchroniser `s1` → `s2`.
  - A debounced level `d` with a counter `c`.
- **Debounce rule** (each cycle):
  - If `s2 == d`: `c <= 0`.
  - Else if `c == DEBOUNCE_CYCLES-1`: `d <= s2`, `c <= 0`.
  - Else: `c <= c+1`.
  - Net effect: `d` follows `s2` only after `s2` has differed from `d` for `DEBOUNCE_CYCLES` consecutive cycles. Any return to equality restarts the count.
- **Octave toggle:**
  - The rising edge of debounced `d_oct` is detected against a registered copy.
  - On each rising edge, `higher_8` toggles.
  - Releasing the button has no effect.
- **Priority encode:**
  - `deg` = 1 + index of the lowest-numbered asserted debounced key.
  - `deg` = 0 if no key is asserted.
- **Note output:**
  - `note_next` = 0 if `deg` == 0; otherwise `{higher_8_next, deg[2:0]}`.
  - `higher_8_next` is the post-toggle value, so a toggle and a key change on the same edge produce a consistent code.
  - `note_out <= note_next` every cycle.
  - `note_change <= (note_next != note_out)`.
- **Octave toggle while a key is held:** `note_out` jumps octave (e.g. 3 ↔ 11) and `note_change` pulses.
- **Octave toggle while resting:** `note_out` stays 0 and there is no pulse. Only `higher_8` changes.

## Timing
- **Reset values:**
  - All `s1`, `s2`, `d`, `c` and edge registers = 0 (all keys released).
  - `note_out` = 0, `higher_8` = 0, `note_change` = 0.
  - Reset is asynchronous, so mid-debounce progress is discarded.
- **Latency** (input pin changes and is held; edge 1 is the first edge that samples it):
  - `s2` updates at edge 2.
  - `d` updates at edge `2+DEBOUNCE_CYCLES`.
  - `note_out`, `higher_8` and `note_change` update at edge `3+DEBOUNCE_CYCLES`.
  - Release has the same latency.
- **Glitch rejection:** a pulse of fewer than `DEBOUNCE_CYCLES` cycles at `s2` never changes `d`.
- **Duration:** `note_change` is exactly one cycle per distinct new value. A steady code produces no further pulses.
- **Simultaneous keys:** the lowest index always wins.
  - Releasing the winner while others are held moves to the next-lowest held key after the debounce latency, with no intermediate 0 unless all keys are released.
- **Counter wrap:** `c` never exceeds `DEBOUNCE_CYCLES-1`, so there is no overflow.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
- **Reset:** assert `rst` with all inputs toggling → `note_out`=0, `higher_8`=0, `note_change`=0 throughout. Deassert with inputs low → outputs stay 0.
- **Single key:** hold `key_in`=7'b0000100 from edge 1 → `note_out`=3 at edge 7, `note_change` high for exactly one cycle. Release → `note_out`=0 at 7 edges after release, with one pulse.
- **Glitch:** `key_in[0]` high for 3 cycles, then low → `note_out` stays 0 and there is no pulse. A 4-cycle hold → `note_out`=1.
- **Priority:** hold bits 1 and 5 → `note_out`=2. Release bit 1 → `note_out`=6 directly, with one pulse.
- **Octave:** hold bit 6 (`note_out`=7), then press and release `octave_btn` → `higher_8`=1 and `note_out`=15 on the same edge, one pulse. Press again → 7. With no key held, a press toggles `higher_8` only and `note_out` stays 0 with no pulse.
- **Reset mid-debounce:** hold bit 3 for 3 stable cycles, pulse `rst`, then keep holding → `note_out` reaches 4 only at a full 7 edges after reset deassertion.

Source files
------------

// File: rtl/note_key_encoder_if.sv
// Board-facing bundle for the free-play note front-end: raw key/octave inputs
// and the encoded note outputs consumed by the free-mode player.
interface note_key_encoder_if;
    logic [6:0] key_in;
    logic       octave_btn;
    logic [3:0] note_out;
    logic       higher_8;
    logic       note_change;

    // Board/stimulus side drives the raw buttons and observes the code.
    modport master (
        output key_in,
        output octave_btn,
        input  note_out,
        input  higher_8,
        input  note_change
    );

    // Encoder side consumes the raw buttons and produces the code.
    modport slave (
        input  key_in,
        input  octave_btn,
        output note_out,
        output higher_8,
        output note_change
    );
endinterface

// File: rtl/note_key_encoder.sv
// Synchronises and debounces seven note keys plus the octave button, then
// priority-encodes the held key into a 4-bit note code with a change pulse.
module note_key_encoder #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    note_key_encoder_if.slave    bus
);
    localparam int NUM_CHAN = 8;
    localparam int CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CHAN-1:0] raw_in;
    logic [NUM_CHAN-1:0] deb_level;

    // Channel 7 is the octave button; channels 0..6 are the note keys.
    assign raw_in = {bus.octave_btn, bus.key_in};

    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        logic          s1_q;
        logic          s2_q;
        logic          d_q;
        logic          d_d;
        logic [CW-1:0] c_q;
        logic [CW-1:0] c_d;

        // The count only runs while s2 disagrees with the accepted level, so
        // any return to agreement restarts the stability window.
        always_comb begin
            d_d = d_q;
            c_d = c_q;
            if (s2_q == d_q) begin
                c_d = '0;
            end else if (c_q == C_MAX) begin
                d_d = s2_q;
                c_d = '0;
            end else begin
                c_d = c_q + CW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
                d_q  <= 1'b0;
                c_q  <= '0;
            end else begin
                s1_q <= raw_in[gi];
                s2_q <= s1_q;
                d_q  <= d_d;
                c_q  <= c_d;
            end
        end

        assign deb_level[gi] = d_q;
    end

    logic       oct_prev_q;
    logic       oct_rise;
    logic       higher_8_q;
    logic       higher_8_d;
    logic [2:0] deg;
    logic [3:0] note_q;
    logic [3:0] note_d;
    logic       note_change_q;
    logic       note_change_d;

    // Scanning from the top down lets the lowest asserted key overwrite last.
    always_comb begin
        deg = 3'd0;
        for (int i = NUM_CHAN - 2; i >= 0; i--) begin
            if (deb_level[i]) begin
                deg = 3'(i + 1);
            end
        end
    end

    // The note code uses the post-toggle octave so a toggle and a key change
    // landing on the same edge produce one consistent code.
    always_comb begin
        oct_rise      = deb_level[NUM_CHAN-1] & ~oct_prev_q;
        higher_8_d    = higher_8_q ^ oct_rise;
        note_d        = (deg == 3'd0) ? 4'd0 : {higher_8_d, deg};
        note_change_d = (note_d != note_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oct_prev_q    <= 1'b0;
            higher_8_q    <= 1'b0;
            note_q        <= 4'd0;
            note_change_q <= 1'b0;
        end else begin
            oct_prev_q    <= deb_level[NUM_CHAN-1];
            higher_8_q    <= higher_8_d;
            note_q        <= note_d;
            note_change_q <= note_change_d;
        end
    end

    assign bus.note_out    = note_q;
    assign bus.higher_8    = higher_8_q;
    assign bus.note_change = note_change_q;
endmodule

// File: tb/tb_note_key_encoder.sv
// Directed bench for note_key_encoder with a short debounce window; inputs
// change on the falling edge and outputs are sampled on the falling edge.
module tb_note_key_encoder;
    localparam int DB = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    note_key_encoder_if bus ();

    note_key_encoder #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] note,
                           input logic hi, input logic chg);
        chk({tag, ".note"},   32'(bus.note_out),    32'(note));
        chk({tag, ".hi8"},    32'(bus.higher_8),    32'(hi));
        chk({tag, ".change"}, 32'(bus.note_change), 32'(chg));
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        clk            = 1'b0;
        rst            = 1'b1;
        bus.key_in     = 7'd0;
        bus.octave_btn = 1'b0;

        // Reset held with inputs toggling: outputs must stay quiet.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.key_in     = 7'($urandom);
            bus.octave_btn = ~bus.octave_btn;
            chk_out("rst_hold", 4'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        bus.key_in     = 7'd0;
        bus.octave_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_n(1);
            chk_out("rst_release", 4'd0, 1'b0, 1'b0);
        end

        // Single key: degree 3 appears at edge 3+DB.
        bus.key_in = 7'b0000100;
        wait_n(6);
        chk_out("key3_e6", 4'd0, 1'b0, 1'b0);
        wait_n(1);
        chk_out("key3_e7", 4'd3, 1'b0, 1'b1);
        wait_n(1);
        chk_out("key3_e8", 4'd3, 1'b0, 1'b0);
        wait_n(5);
        chk_out("key3_steady", 4'd3, 1'b0, 1'b0);
        bus.key_in = 7'd0;
        wait_n(6);
        chk_out("rel3_e6", 4'd3, 1'b0, 1'b0);
        wait_n(1);
        chk_out("rel3_e7", 4'd0, 1'b0, 1'b1);
        wait_n(1);
        chk_out("rel3_e8", 4'd0, 1'b0, 1'b0);

        // Glitch of DB-1 cycles is rejected.
        bus.key_in = 7'b0000001;
        wait_n(DB - 1);
        bus.key_in = 7'd0;
        for (int i = 0; i < 12; i++) begin
            wait_n(1);
            chk_out("glitch3", 4'd0, 1'b0, 1'b0);
        end
        // A DB-cycle pulse is accepted.
        bus.key_in = 7'b0000001;
        wait_n(DB);
        bus.key_in = 7'd0;
        wait_n(2);
        chk_out("pulse4_e6", 4'd0, 1'b0, 1'b0);
        wait_n(1);
        chk_out("pulse4_e7", 4'd1, 1'b0, 1'b1);
        wait_n(15);
        chk_out("pulse4_settle", 4'd0, 1'b0, 1'b0);

        // Priority: bits 1 and 5 -> 2; dropping bit 1 goes straight to 6.
        bus.key_in = 7'b0100010;
        wait_n(7);
        chk_out("prio_e7", 4'd2, 1'b0, 1'b1);
        wait_n(3);
        bus.key_in = 7'b0100000;
        wait_n(6);
        chk_out("prio_rel_e6", 4'd2, 1'b0, 1'b0);
        wait_n(1);
        chk_out("prio_rel_e7", 4'd6, 1'b0, 1'b1);
        wait_n(1);
        chk_out("prio_rel_e8", 4'd6, 1'b0, 1'b0);
        bus.key_in = 7'd0;
        wait_n(10);
        chk_out("prio_clear", 4'd0, 1'b0, 1'b0);

        // Octave with key 7 held: 7 -> 15 -> 7.
        bus.key_in = 7'b1000000;
        wait_n(7);
        chk_out("oct_key7", 4'd7, 1'b0, 1'b1);
        wait_n(3);
        bus.octave_btn = 1'b1;
        wait_n(6);
        chk_out("oct_up_e6", 4'd7, 1'b0, 1'b0);
        wait_n(1);
        chk_out("oct_up_e7", 4'd15, 1'b1, 1'b1);
        wait_n(1);
        chk_out("oct_up_e8", 4'd15, 1'b1, 1'b0);
        bus.octave_btn = 1'b0;
        wait_n(10);
        chk_out("oct_btn_rel", 4'd15, 1'b1, 1'b0);
        bus.octave_btn = 1'b1;
        wait_n(7);
        chk_out("oct_down_e7", 4'd7, 1'b0, 1'b1);
        bus.octave_btn = 1'b0;
        wait_n(10);
        bus.key_in = 7'd0;
        wait_n(10);
        chk_out("oct_key_rel", 4'd0, 1'b0, 1'b0);
        // Octave press while resting toggles only the flag.
        bus.octave_btn = 1'b1;
        wait_n(6);
        chk_out("oct_rest_e6", 4'd0, 1'b0, 1'b0);
        wait_n(1);
        chk_out("oct_rest_e7", 4'd0, 1'b1, 1'b0);
        wait_n(1);
        chk_out("oct_rest_e8", 4'd0, 1'b1, 1'b0);
        bus.octave_btn = 1'b0;
        wait_n(10);

        // Reset mid-debounce discards progress.
        bus.key_in = 7'b0001000;
        wait_n(5);
        rst = 1'b1;
        wait_n(1);
        chk_out("mid_rst", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_n(6);
        chk_out("mid_rst_e6", 4'd0, 1'b0, 1'b0);
        wait_n(1);
        chk_out("mid_rst_e7", 4'd4, 1'b0, 1'b1);
        wait_n(1);
        chk_out("mid_rst_e8", 4'd4, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
